// File: rtl/bcd_rtc_param.sv
// BCD time-of-day clock: prescaled 1 s tick, 24-hour internal time, 12/24-hour display.
// Strobes are registered one-cycle pulses; out/pm are combinational from the time registers.
module bcd_rtc_param #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        run,
  input  logic        load,
  input  logic [23:0] set_time,
  input  logic        mode_12h,
  output logic [23:0] out,
  output logic        pm,
  output logic        sec_tick,
  output logic        rollover,
  output logic        load_err
);
  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PC_LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] pc;
  logic [3:0] h1, h0, m1, m0, s1, s0;
  logic [3:0] n_h1, n_h0, n_m1, n_m0, n_s1, n_s0;
  logic [3:0] d_h1, d_h0;
  logic       wrap;
  logic       set_ok;

  assign set_ok = (set_time[3:0]   <= 4'd9) && (set_time[7:4]   <= 4'd5) &&
                  (set_time[11:8]  <= 4'd9) && (set_time[15:12] <= 4'd5) &&
                  (set_time[19:16] <= 4'd9) && (set_time[23:20] <= 4'd2) &&
                  !((set_time[23:20] == 4'd2) && (set_time[19:16] > 4'd3));

  // Each stage only moves when every lower stage wraps.
  always_comb begin
    n_h1 = h1; n_h0 = h0; n_m1 = m1; n_m0 = m0; n_s1 = s1; n_s0 = s0;
    wrap = 1'b0;
    if (s0 != 4'd9) begin
      n_s0 = s0 + 4'd1;
    end else begin
      n_s0 = 4'd0;
      if (s1 != 4'd5) begin
        n_s1 = s1 + 4'd1;
      end else begin
        n_s1 = 4'd0;
        if (m0 != 4'd9) begin
          n_m0 = m0 + 4'd1;
        end else begin
          n_m0 = 4'd0;
          if (m1 != 4'd5) begin
            n_m1 = m1 + 4'd1;
          end else begin
            n_m1 = 4'd0;
            if (h1 == 4'd2 && h0 == 4'd3) begin
              n_h1 = 4'd0;
              n_h0 = 4'd0;
              wrap = 1'b1;
            end else if (h0 == 4'd9) begin
              n_h0 = 4'd0;
              n_h1 = h1 + 4'd1;
            end else begin
              n_h0 = h0 + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      pc       <= '0;
      {h1, h0, m1, m0, s1, s0} <= 24'h000000;
      sec_tick <= 1'b0;
      rollover <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      rollover <= 1'b0;
      load_err <= 1'b0;
      if (load && set_ok) begin
        {h1, h0, m1, m0, s1, s0} <= set_time;
        pc <= '0;
      end else begin
        load_err <= load;
        if (run) begin
          if (pc == PC_LAST) begin
            pc       <= '0;
            {h1, h0, m1, m0, s1, s0} <= {n_h1, n_h0, n_m1, n_m0, n_s1, n_s0};
            sec_tick <= 1'b1;
            rollover <= wrap;
          end else begin
            pc <= pc + PW'(1);
          end
        end
      end
    end
  end

  // 12-hour remap: 00 -> 12, 13..23 -> 01..11 (BCD subtract 12 per tens digit).
  always_comb begin
    d_h1 = h1;
    d_h0 = h0;
    if (mode_12h) begin
      if (h1 == 4'd0 && h0 == 4'd0) begin
        d_h1 = 4'd1;
        d_h0 = 4'd2;
      end else if (h1 == 4'd1 && h0 >= 4'd3) begin
        d_h1 = 4'd0;
        d_h0 = h0 - 4'd2;
      end else if (h1 == 4'd2 && h0 <= 4'd1) begin
        d_h1 = 4'd0;
        d_h0 = h0 + 4'd8;
      end else if (h1 == 4'd2) begin
        d_h1 = 4'd1;
        d_h0 = h0 - 4'd2;
      end
    end
  end

  assign out = {d_h1, d_h0, m1, m0, s1, s0};
  assign pm  = (h1 == 4'd2) || (h1 == 4'd1 && h0 >= 4'd2);
endmodule

// File: tb/tb_bcd_rtc_param.sv
// Self-checking bench for bcd_rtc_param with TICKS_PER_SEC=4: directed tables,
// hand-written corner sequences and a randomized run against a seconds-of-day model.
module tb_bcd_rtc_param;
  localparam int T = 4;

  logic        CLK100MHZ = 1'b0;
  logic        reset, run, load, mode_12h;
  logic [23:0] set_time;
  logic [23:0] out;
  logic        pm, sec_tick, rollover, load_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: time as seconds since midnight plus a prescale count.
  int m_tod, m_pc;
  bit m_tick, m_roll, m_err;

  bcd_rtc_param #(.TICKS_PER_SEC(T)) dut (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .run(run), .load(load),
    .set_time(set_time), .mode_12h(mode_12h), .out(out), .pm(pm),
    .sec_tick(sec_tick), .rollover(rollover), .load_err(load_err)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct {
    bit          ld;
    logic [23:0] st;
    bit          m12;
    logic [23:0] exp_out;
    bit          exp_pm;
    bit          exp_err;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [23:0] fmt(int t, bit m12);
    int h, mi, s;
    h = t / 3600; mi = (t / 60) % 60; s = t % 60;
    if (m12) begin
      h = h % 12;
      if (h == 0) h = 12;
    end
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bit legal(logic [23:0] v);
    for (int i = 0; i < 6; i++)
      if (v[i*4 +: 4] > 4'd9) return 1'b0;
    return (int'(v[23:20]) * 10 + int'(v[19:16]) < 24) &&
           (int'(v[15:12]) * 10 + int'(v[11:8]) < 60) &&
           (int'(v[7:4]) * 10 + int'(v[3:0]) < 60);
  endfunction

  function automatic int tod_of(logic [23:0] v);
    return (int'(v[23:20]) * 10 + int'(v[19:16])) * 3600 +
           (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 +
           int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  task automatic model_reset();
    m_tod = 0; m_pc = 0; m_tick = 0; m_roll = 0; m_err = 0;
  endtask

  task automatic model_edge();
    m_tick = 0; m_roll = 0; m_err = 0;
    if (load && legal(set_time)) begin
      m_tod = tod_of(set_time);
      m_pc  = 0;
    end else begin
      m_err = load;
      if (run) begin
        if (m_pc == T - 1) begin
          m_pc   = 0;
          m_tod  = (m_tod + 1) % 86400;
          m_tick = 1;
          m_roll = (m_tod == 0);
        end else begin
          m_pc++;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("model_out", out, fmt(m_tod, mode_12h));
    chk("model_pm", 24'(pm), 24'(m_tod >= 43200));
    chk("model_tick", 24'(sec_tick), 24'(m_tick));
    chk("model_roll", 24'(rollover), 24'(m_roll));
    chk("model_err", 24'(load_err), 24'(m_err));
  endtask

  task automatic step();
    @(posedge CLK100MHZ);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_load(input logic [23:0] v);
    load = 1'b1; set_time = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1, 24'h000000, 1, 24'h120000, 0, 0};
    tbl[1] = '{1, 24'h093000, 1, 24'h093000, 0, 0};
    tbl[2] = '{1, 24'h120000, 1, 24'h120000, 1, 0};
    tbl[3] = '{1, 24'h134500, 1, 24'h014500, 1, 0};
    tbl[4] = '{1, 24'h235959, 1, 24'h115959, 1, 0};
    tbl[5] = '{1, 24'h134500, 0, 24'h134500, 1, 0};
    tbl[6] = '{1, 24'h246000, 0, 24'h134500, 1, 1};
    tbl[7] = '{1, 24'h006000, 0, 24'h134500, 1, 1};
    tbl[8] = '{1, 24'h0A0000, 0, 24'h134500, 1, 1};

    reset = 1'b1; run = 1'b0; load = 1'b0; set_time = 24'h0; mode_12h = 1'b0;
    model_reset();
    #2;
    chk("reset_out", out, 24'h000000);
    chk("reset_pm", 24'(pm), 24'h0);
    chk("reset_strobes", {21'b0, sec_tick, rollover, load_err}, 24'h0);
    mode_12h = 1'b1; #1;
    chk("reset_out_12h", out, 24'h120000);
    mode_12h = 1'b0;

    // Free run from reset release.
    #9; reset = 1'b0; run = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 3)  chk("t1_before_tick", out, 24'h000000);
      if (i == 4)  chk("t1_first_out", out, 24'h000001);
      if (i == 4)  chk("t1_first_tick", 24'(sec_tick), 24'h1);
      if (i == 5)  chk("t1_tick_pulse", 24'(sec_tick), 24'h0);
      if (i == 40) chk("t1_ten_sec", out, 24'h000010);
    end

    // Midnight rollover and hour cascade.
    do_load(24'h235958);
    chk("t2_loaded", out, 24'h235958);
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 4) chk("t2_5959", out, 24'h235959);
      if (i == 8) chk("t2_midnight", out, 24'h000000);
      if (i == 8) chk("t2_roll_tick", {22'b0, rollover, sec_tick}, 24'h3);
      if (i == 9) chk("t2_roll_pulse", 24'(rollover), 24'h0);
    end
    do_load(24'h095959);
    for (int i = 0; i < 4; i++) step();
    chk("t2_cascade", out, 24'h100000);

    // Table: 12-hour formatting and rejected loads, time held.
    run = 1'b0;
    for (int i = 0; i < 9; i++) begin
      mode_12h = tbl[i].m12;
      load = tbl[i].ld; set_time = tbl[i].st;
      step();
      load = 1'b0;
      chk($sformatf("tbl%0d_out", i), out, tbl[i].exp_out);
      chk($sformatf("tbl%0d_pm", i), 24'(pm), 24'(tbl[i].exp_pm));
      chk($sformatf("tbl%0d_err", i), 24'(load_err), 24'(tbl[i].exp_err));
      step();
      chk($sformatf("tbl%0d_err_pulse", i), 24'(load_err), 24'h0);
    end
    mode_12h = 1'b1; #1;
    chk("t3_12h_view", out, 24'h014500);
    mode_12h = 1'b0; #1;
    chk("t3_mode_same_cycle", out, 24'h134500);

    // Hold mid-count, then load on the terminal-count edge.
    run = 1'b1;
    do_load(24'h000000);
    step(); step();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_hold_tick", 24'(sec_tick), 24'h0);
      chk("t5_hold_out", out, 24'h000000);
    end
    run = 1'b1;
    step();
    chk("t5_resume_no_tick", 24'(sec_tick), 24'h0);
    step();
    chk("t5_resume_tick", 24'(sec_tick), 24'h1);
    chk("t5_resume_out", out, 24'h000001);
    step(); step(); step();
    do_load(24'h121212);
    chk("t5_collide_out", out, 24'h121212);
    chk("t5_collide_tick", 24'(sec_tick), 24'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t5_after_collide_tick", 24'(sec_tick), 24'(i == 4));
    end
    chk("t5_after_collide_out", out, 24'h121213);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      run = ($urandom_range(0, 9) != 0);
      mode_12h = $urandom_range(0, 1);
      load = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 1) == 0) set_time = fmt(int'($urandom_range(0, 86399)), 1'b0);
      else set_time = 24'($urandom);
      if (i % 97 == 0) begin
        load = 1'b1; set_time = 24'h235957;
      end
      step();
    end
    load = 1'b0;

    // Asynchronous reset between edges while a tick is showing.
    run = 1'b1; mode_12h = 1'b0;
    do_load(24'h123455);
    for (int i = 0; i < 4; i++) step();
    chk("t6_pre_out", out, 24'h123456);
    chk("t6_pre_tick", 24'(sec_tick), 24'h1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("t6_async_out", out, 24'h000000);
    chk("t6_async_pm", 24'(pm), 24'h0);
    chk("t6_async_tick", 24'(sec_tick), 24'h0);
    #10;
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bcd_rtc_param.md
# bcd_rtc_param

Parametrised BCD time-of-day clock that replaces the fixed `clock` block in the alarm-clock design. It divides `CLK100MHZ` down to a one-second tick and keeps HH:MM:SS internally in 24-hour BCD. It presents that time on a 24-bit BCD bus in either 24-hour or 12-hour format. Over the fixed block it adds a run/hold enable, synchronous time loading with validity checking, a 12/24-hour display mode, and tick and midnight strobes for downstream alarm-compare and display logic.

## Interface

Parameters:
- `TICKS_PER_SEC`, default 100_000_000: number of `CLK100MHZ` cycles per second. Legal range is ≥2. Benches use 4.

Ports:
- `CLK100MHZ`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  1 = prescaler and time advance; 0 = hold.
- `load`  in  1  single-cycle strobe: write `set_time` into the time registers.
- `set_time`  in  24  BCD {H1,H0,M1,M0,S1,S0}, always in 24-hour format.
- `mode_12h`  in  1  0 = 24-hour output; 1 = 12-hour output.
- `out`  out  24  BCD {H1,H0,M1,M0,S1,S0} in the format selected by `mode_12h`.
- `pm`  out  1  1 when the internal hour is 12–23, in either mode.
- `sec_tick`  out  1  one-cycle pulse, high in the cycle the new second is present.
- `rollover`  out  1  one-cycle pulse on the 23:59:59 → 00:00:00 transition.
- `load_err`  out  1  one-cycle pulse when a `load` was rejected.

## Operation

- **State:** a prescaler counter `pc` of width clog2(`TICKS_PER_SEC`), plus six BCD digit registers holding 24-hour time.
- **Reset (asynchronous):** `pc`=0 and time=00:00:00. `sec_tick`, `rollover` and `load_err` all go to 0. As a result `out`=24'h000000 (or 24'h120000 when `mode_12h`=1) and `pm`=0.
- **Edge priority:** evaluated in this order on each rising edge.
  1. **`load`=1, `set_time` valid:**
     - Time ← `set_time` and `pc` ← 0.
     - `sec_tick` and `rollover` are 0; `load_err` is 0.
     - This happens regardless of `run`.
  2. **`load`=1, `set_time` invalid:**
     - Time is unchanged and `pc` continues as it would with `load`=0.
     - `load_err` goes to 1 for one cycle.
     - A tick may still occur on this edge.
  3. **`run`=1 and `pc`=`TICKS_PER_SEC`-1:**
     - `pc` ← 0, time advances by one second, and `sec_tick` goes to 1.
  4. **`run`=1 otherwise:** `pc` ← `pc`+1.
  5. **`run`=0:** `pc` and time hold, and all strobes are 0.
- **Validity check:** `set_time` is valid only if every nibble is ≤9, S1≤5, M1≤5, and the hour is ≤23 (H1≤2, and H0≤3 when H1=2).
- **Increment cascade:**
  - S0 9→0 carries into S1; S1:S0 59→00 carries into M0.
  - M0 9→0 carries into M1; M1:M0 59→00 carries into H0.
  - H0 9→0 carries into H1.
  - Hour 23→00 sets `rollover`=1 in the same cycle as `sec_tick`.
- **Output formatting** (combinational from the time registers and `mode_12h`; mode changes take effect in the same cycle):
  - 24-hour mode: `out` = internal time.
  - 12-hour mode, hour 00: displayed hour is 12.
  - 12-hour mode, hours 01–12: displayed hour unchanged.
  - 12-hour mode, hours 13–23: displayed hour is hour−12, in BCD (13→01, 20→08, 23→11).
  - Minutes and seconds pass through unchanged.
- **Storage invariant:** internal time is always legal 24-hour BCD. No illegal value can be stored.

## Timing

- **First tick:** with `run` held at 1 from reset release, `sec_tick` is first high after the `TICKS_PER_SEC`-th rising edge. After that it recurs every `TICKS_PER_SEC` cycles.
- **Registered outputs:**
  - `sec_tick`, `rollover` and `load_err` are registered and high for exactly one cycle.
  - `out` shows the new second in the same cycle `sec_tick` is high.
- **Load latency:** `out` reflects a valid load after the edge on which `load` was sampled, i.e. 1 cycle. The next `sec_tick` follows exactly `TICKS_PER_SEC` run cycles later.
- **Run/hold:** `run` deasserted mid-count freezes `pc`. On reassertion the count resumes from the frozen value; no partial second is lost or restarted.
- **Load vs. tick:** a valid `load` on the same edge as the prescaler terminal count wins. No tick occurs, and the second restarts.
- **Reset mid-operation:** reset clears all state immediately without waiting for a clock edge. A strobe that is high drops in that same instant.

## Test plan

All scenarios use `TICKS_PER_SEC`=4.

1. **Reset and free run:** assert reset, release it, hold `run`=1. Required: `out`=000000 until the 4th edge. Then `out`=000001 with `sec_tick` high for 1 cycle. After 40 edges, `out`=000010.
2. **Midnight rollover and cascade:**
   - Load 235958, then run 8 cycles. Required: 235959, then 000000 with `rollover` and `sec_tick` both high in the same single cycle.
   - Load 095959 and run 4 cycles. Required: 100000.
3. **12-hour formatting:**
   - Loads 000000, 093000, 120000, 134500 and 235959 with `mode_12h`=1.
   - Required `out`/`pm`: 120000/0, 093000/0, 120000/1, 014500/1, 115959/1.
   - Toggling `mode_12h` to 0 at 134500 shows 134500 in the same cycle.
4. **Invalid loads:** load 246000, then 006000, then 0A0000. Required: each produces `load_err`=1 for one cycle, and time is unchanged from its prior value.
5. **Hold and load-vs-tick collision:**
   - Drop `run` for 10 cycles at `pc`=2. Required: `out` frozen and no `sec_tick`; the tick comes 2 cycles after `run` returns.
   - Assert a valid `load` exactly on the terminal-count edge. Required: loaded value shown, no `sec_tick`, next tick 4 cycles later.
6. **Asynchronous reset mid-count:** assert reset between edges at time 123456. Required: `out` and `pm` go to 000000/0 and `sec_tick` to 0 before the next clock edge.
